// File: rtl/dcu_pkg.sv
// Shared types and encodings for the datapath control unit.
package dcu_pkg;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    IC_R,
    IC_I,
    IC_LD,
    IC_ST,
    IC_B,
    IC_CBZ,
    IC_ILL
  } iclass_e;

  // 11-bit opcodes in IR[31:21]
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_EOR  = 11'h650;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  // 10-bit opcodes in IR[31:22]
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  // 8-bit opcode in IR[31:24], 6-bit opcode in IR[31:26]
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic [4:0] fs;
    logic       c_in;
    logic       b_sel;
  } cw_t;

  // Quiet control word: all selects on XZR, ALU in AND, register B operand
  function automatic cw_t cw_idle();
    cw_t c;
    c.sa    = XZR;
    c.sb    = XZR;
    c.da    = XZR;
    c.fs    = FS_AND;
    c.c_in  = 1'b0;
    c.b_sel = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/datapath_control_unit_decoder.sv
// Combinational instruction decode: IR to register selects, ALU setup,
// immediate and instruction class. Enables are left to the sequencer.
module dcu_decoder
  import dcu_pkg::*;
#(
  parameter int K_W = 64
) (
  input  logic [31:0]    ir,
  output cw_t            cw,
  output logic [K_W-1:0] k,
  output iclass_e        iclass
);

  // Classify the opcode and build the static part of the control word
  always_comb begin
    cw     = cw_idle();
    k      = '0;
    iclass = IC_ILL;
    if (ir[31:21] == OP_LDUR || ir[31:21] == OP_STUR) begin
      iclass   = (ir[31:21] == OP_LDUR) ? IC_LD : IC_ST;
      cw.sa    = ir[9:5];
      cw.fs    = FS_ADD;
      cw.b_sel = 1'b1;
      k        = {{(K_W-9){ir[20]}}, ir[20:12]};
      if (ir[31:21] == OP_STUR) cw.sb = ir[4:0];
    end else if (ir[31:21] == OP_ADD || ir[31:21] == OP_SUB ||
                 ir[31:21] == OP_AND || ir[31:21] == OP_ORR ||
                 ir[31:21] == OP_EOR) begin
      iclass = IC_R;
      cw.sa  = ir[9:5];
      cw.sb  = ir[20:16];
      cw.da  = ir[4:0];
      case (ir[31:21])
        OP_ADD:  cw.fs = FS_ADD;
        OP_SUB:  begin cw.fs = FS_SUB; cw.c_in = 1'b1; end
        OP_ORR:  cw.fs = FS_ORR;
        OP_EOR:  cw.fs = FS_EOR;
        default: cw.fs = FS_AND;
      endcase
    end else if (ir[31:22] == OP_ADDI || ir[31:22] == OP_SUBI) begin
      iclass   = IC_I;
      cw.sa    = ir[9:5];
      cw.da    = ir[4:0];
      cw.b_sel = 1'b1;
      k        = {{(K_W-12){1'b0}}, ir[21:10]};
      if (ir[31:22] == OP_SUBI) begin
        cw.fs   = FS_SUB;
        cw.c_in = 1'b1;
      end else begin
        cw.fs   = FS_ADD;
      end
    end else if (ir[31:24] == OP_CBZ) begin
      // XZR + Rt through the ALU so Z reports Rt == 0
      iclass = IC_CBZ;
      cw.sa  = XZR;
      cw.sb  = ir[4:0];
      cw.fs  = FS_ADD;
    end else if (ir[31:26] == OP_B) begin
      iclass = IC_B;
    end
  end

endmodule

// File: rtl/datapath_control_unit.sv
// Multi-cycle LEGv8-subset sequencer: fetches instructions, drives the
// Datapath control word, sequences data memory and owns the PC.
module datapath_control_unit
  import dcu_pkg::*;
#(
  parameter int PC_W = 64,
  parameter int K_W  = 64
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] pc,
  output logic            instr_req,
  input  logic            instr_valid,
  input  logic [31:0]     instr_data,
  input  logic [3:0]      status,
  output logic [4:0]      SA,
  output logic [4:0]      SB,
  output logic [4:0]      DA,
  output logic            W,
  output logic [4:0]      FS,
  output logic            C_in,
  output logic            B_SEL,
  output logic [K_W-1:0]  K,
  output logic            EN_B,
  output logic            EN_ALU,
  output logic            EN_MEM,
  output logic            mem_rd,
  output logic            mem_wr,
  input  logic            mem_ready,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            halted_q, halted_d;

  cw_t             dec_cw, cw_o;
  logic [K_W-1:0]  dec_k, k_o;
  iclass_e         dec_class;

  logic [PC_W-1:0]        pc_inc;
  logic signed [PC_W-1:0] b_off, cbz_off;
  logic                   unused_status;

  assign unused_status = ^status[3:1];
  assign pc_inc  = pc_q + PC_W'(4);
  // Branch displacements are word offsets; the adds wrap modulo 2^PC_W
  assign b_off   = {{(PC_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
  assign cbz_off = {{(PC_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};

  dcu_decoder #(.K_W(K_W)) u_decoder (
    .ir     (ir_q),
    .cw     (dec_cw),
    .k      (dec_k),
    .iclass (dec_class)
  );

  // Next-state, PC update and control-word generation
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    cw_o      = cw_idle();
    k_o       = '0;
    instr_req = 1'b0;
    W         = 1'b0;
    EN_B      = 1'b0;
    EN_ALU    = 1'b0;
    EN_MEM    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Reset is asynchronous, so the request must drop with it
        instr_req = ~reset;
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cw_o    = dec_cw;
        k_o     = dec_k;
        state_d = S_FETCH;
        case (dec_class)
          IC_R, IC_I: begin
            EN_ALU = 1'b1;
            W      = 1'b1;
            pc_d   = pc_inc;
          end
          IC_LD, IC_ST: begin
            EN_ALU  = 1'b1;
            state_d = S_MEM;
          end
          IC_B:   pc_d = pc_q + $unsigned(b_off);
          IC_CBZ: pc_d = status[0] ? pc_q + $unsigned(cbz_off) : pc_inc;
          default: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        // Address operands stay on the ALU for the whole access
        cw_o = dec_cw;
        k_o  = dec_k;
        if (dec_class == IC_LD) begin
          cw_o.da = ir_q[4:0];
          mem_rd  = 1'b1;
          EN_MEM  = 1'b1;
          W       = mem_ready;
        end else begin
          mem_wr  = 1'b1;
          EN_B    = 1'b1;
        end
        if (mem_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // Control state, PC and trap flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Instruction register; only read after a completed fetch
  always_ff @(posedge clock) begin
    ir_q <= ir_d;
  end

  assign pc     = pc_q;
  assign halted = halted_q;
  assign SA     = cw_o.sa;
  assign SB     = cw_o.sb;
  assign DA     = cw_o.da;
  assign FS     = cw_o.fs;
  assign C_in   = cw_o.c_in;
  assign B_SEL  = cw_o.b_sel;
  assign K      = k_o;

endmodule
